pipe_stage_reg: RTL and testbench

Parametrised pipeline-stage register with a valid/ready handshake, an optional skid entry, synchronous flush and a configurable bubble payload. It is the generalised replacement for fixed-width inter-stage latches such as IF/ID in the five-stage core. It carries any payload width. It gives true back-pressure, so a stall does not lose or duplicate data. Whenever it holds no valid entry, it drives a known bubble, for example a NOP instruction with PC 0.

---
 rtl/pipe_stage_reg_if.sv | 53 +++++
 rtl/pipe_stage_reg.sv | 138 +++++++++++++
 tb/tb_pipe_stage_reg.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_reg_if.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg_if
//   Groups the handshake, payload and status signals of one pipeline stage
//   register.
//
//   Signals
//     flush      : synchronous kill of every held entry
//     in_valid   : upstream has a payload
//     in_ready   : stage accepts a payload this cycle
//     in_data    : upstream payload
//     out_valid  : out_data is a valid entry
//     out_ready  : downstream consumes this cycle
//     out_data   : payload to the next stage
//     occupancy  : number of held entries (0..2)
//
//   Modports
//     master : the side that drives the stage (upstream + downstream agents)
//     slave  : the stage register itself
// -----------------------------------------------------------------------------
interface pipe_stage_reg_if #(
    parameter int DATA_W = 64
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occupancy;

    modport master (
        output flush,
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  occupancy
    );

    modport slave (
        input  flush,
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output occupancy
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//   Pipeline-stage register with valid/ready handshake, optional skid entry,
//   synchronous flush and a configurable bubble payload shown whenever the
//   stage holds nothing valid (e.g. NOP with PC 0 for an IF/ID latch).
//
//   Parameters
//     DATA_W : payload width in bits
//     BUBBLE : payload presented on out_data after reset, flush or drain
//     SKID   : 1 = two entries, registered in_ready
//              0 = one entry, combinational in_ready
//
//   Ports
//     clk    : clock, all state changes on the rising edge
//     rst_n  : asynchronous active-low reset
//     bus    : pipe_stage_reg_if.slave (handshake, payloads, flush, occupancy)
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   ST_EMPTY  | nothing held, out_valid=0, out_data=BUBBLE
//   ST_ONE    | main register valid, skid empty
//   ST_TWO    | main and skid both valid (only reachable with SKID=1)
//
//   The state encoding equals the entry count, so occupancy is the state
//   register itself and always agrees with out_valid.
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int              DATA_W = 64,
    parameter logic [DATA_W-1:0] BUBBLE = DATA_W'(64'h0000_0000_0000_0013),
    parameter bit              SKID   = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    pipe_stage_reg_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t            state;
    logic              main_valid;
    logic [DATA_W-1:0] main_data;
    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic              in_ready_q;

    logic              in_ready_w;
    logic              in_fire;
    logic              out_fire;

    // With a skid entry, in_ready is a flop (no path from out_ready);
    // without one, the single entry can be refilled in the cycle it drains.
    assign in_ready_w = SKID ? in_ready_q : (!main_valid | bus.out_ready);

    assign in_fire  = bus.in_valid & in_ready_w;
    assign out_fire = main_valid & bus.out_ready;

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = main_valid;
    assign bus.out_data  = main_data;
    assign bus.occupancy = 2'(state);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_EMPTY;
            main_valid <= 1'b0;
            main_data  <= BUBBLE;
            skid_valid <= 1'b0;
            skid_data  <= BUBBLE;
            in_ready_q <= 1'b1;
        end else if (bus.flush) begin
            // Any same-cycle in_fire is dropped; an out_fire was already
            // taken by downstream, we just do not refill.
            state      <= ST_EMPTY;
            main_valid <= 1'b0;
            main_data  <= BUBBLE;
            skid_valid <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state      <= ST_ONE;
                        main_valid <= 1'b1;
                        main_data  <= bus.in_data;
                    end
                end

                ST_ONE: begin
                    case ({in_fire, out_fire})
                        2'b11: begin
                            main_data <= bus.in_data;
                        end
                        2'b10: begin
                            // Without a skid entry in_ready already implies
                            // out_ready here, so this arm is SKID-only.
                            if (SKID) begin
                                state      <= ST_TWO;
                                skid_valid <= 1'b1;
                                skid_data  <= bus.in_data;
                                in_ready_q <= 1'b0;
                            end
                        end
                        2'b01: begin
                            state      <= ST_EMPTY;
                            main_valid <= 1'b0;
                            main_data  <= BUBBLE;
                        end
                        default: begin
                        end
                    endcase
                end

                ST_TWO: begin
                    // in_ready is low here, so only a drain can happen.
                    if (out_fire) begin
                        state      <= ST_ONE;
                        main_data  <= skid_data;
                        skid_valid <= 1'b0;
                        in_ready_q <= 1'b1;
                    end
                end

                default: begin
                    state      <= ST_EMPTY;
                    main_valid <= 1'b0;
                    main_data  <= BUBBLE;
                    skid_valid <= 1'b0;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

    localparam int          DW  = 64;
    localparam logic [63:0] BUB = 64'h0000_0000_0000_0013;

    typedef logic [63:0] word_t;

    typedef struct {
        logic       iv;
        word_t      d;
        logic       orr;
        logic       fl;
        logic       ov;
        word_t      od;
        logic [1:0] occ;
        logic       ir;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    pipe_stage_reg_if #(.DATA_W(DW)) bus1 ();
    pipe_stage_reg_if #(.DATA_W(DW)) bus0 ();

    pipe_stage_reg #(.DATA_W(DW), .BUBBLE(BUB), .SKID(1'b1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    pipe_stage_reg #(.DATA_W(DW), .BUBBLE(BUB), .SKID(1'b0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    int    compared   = 0;
    int    mismatched = 0;
    word_t sb1[$];
    word_t sb0[$];
    vec_t  tbl[$];

    task automatic check(input string name, input word_t act, input word_t exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic iv, input word_t d, input logic orr, input logic fl);
        bus1.in_valid  = iv;
        bus1.in_data   = d;
        bus1.out_ready = orr;
        bus1.flush     = fl;
        bus0.in_valid  = iv;
        bus0.in_data   = d;
        bus0.out_ready = orr;
        bus0.flush     = fl;
    endtask

    task automatic add(input logic iv, input word_t d, input logic orr, input logic fl,
                       input logic ov, input word_t od, input logic [1:0] occ, input logic ir);
        vec_t v;
        v.iv = iv; v.d = d; v.orr = orr; v.fl = fl;
        v.ov = ov; v.od = od; v.occ = occ; v.ir = ir;
        tbl.push_back(v);
    endtask

    // Scoreboard: q holds the entries the stage should be holding, oldest
    // first. Checked against the outputs for the current cycle, then
    // advanced by the handshake that the coming rising edge will perform.
    task automatic model_step(input bit skid, input string tag, inout word_t q[$],
                              input logic iv, input logic ir, input logic ov,
                              input logic orr, input logic fl, input word_t id,
                              input word_t od, input logic [1:0] occ);
        bit    exp_ir;
        bit    fire_in;
        bit    fire_out;
        word_t exp_od;
        exp_ir = skid ? (q.size() < 2) : (q.size() == 0 || orr);
        exp_od = (q.size() != 0) ? q[0] : BUB;
        check({tag, "_in_ready"},  word_t'(ir),  word_t'(exp_ir));
        check({tag, "_out_valid"}, word_t'(ov),  word_t'(q.size() != 0));
        check({tag, "_occupancy"}, word_t'(occ), word_t'(q.size()));
        check({tag, "_out_data"},  od,           exp_od);
        fire_out = (q.size() != 0) && orr;
        fire_in  = iv && exp_ir;
        if (fire_out) void'(q.pop_front());
        if (fl) q.delete();
        else if (fire_in) q.push_back(id);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            model_step(1'b1, "s1", sb1, bus1.in_valid, bus1.in_ready, bus1.out_valid,
                       bus1.out_ready, bus1.flush, bus1.in_data, bus1.out_data, bus1.occupancy);
            model_step(1'b0, "s0", sb0, bus0.in_valid, bus0.in_ready, bus0.out_valid,
                       bus0.out_ready, bus0.flush, bus0.in_data, bus0.out_data, bus0.occupancy);
            check("s0_occ_le1", word_t'(bus0.occupancy <= 2'd1), 64'd1);
        end else begin
            sb1.delete();
            sb0.delete();
        end
    end

    task automatic check_reset(input string tag);
        check({tag, "_s1_out_valid"}, word_t'(bus1.out_valid), 64'd0);
        check({tag, "_s1_out_data"},  bus1.out_data,           BUB);
        check({tag, "_s1_in_ready"},  word_t'(bus1.in_ready),  64'd1);
        check({tag, "_s1_occupancy"}, word_t'(bus1.occupancy), 64'd0);
        check({tag, "_s0_out_valid"}, word_t'(bus0.out_valid), 64'd0);
        check({tag, "_s0_out_data"},  bus0.out_data,           BUB);
        check({tag, "_s0_in_ready"},  word_t'(bus0.in_ready),  64'd1);
        check({tag, "_s0_occupancy"}, word_t'(bus0.occupancy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(1'b0, '0, 1'b0, 1'b0);

        //   iv  data            orr  fl |  ov  out_data        occ   ir   (SKID=1 view)
        add(1, 64'hA,            1,   0,    0,  BUB,            2'd0, 1);  // accept A
        add(1, 64'hB,            0,   0,    1,  64'hA,          2'd1, 1);  // stall, B to skid
        add(1, 64'hC,            0,   0,    1,  64'hA,          2'd2, 0);  // C held upstream
        add(1, 64'hC,            0,   0,    1,  64'hA,          2'd2, 0);
        add(1, 64'hC,            1,   0,    1,  64'hA,          2'd2, 0);  // release
        add(1, 64'hC,            1,   0,    1,  64'hB,          2'd1, 1);  // skid moved to main
        add(0, 64'h0,            1,   0,    1,  64'hC,          2'd1, 1);
        add(0, 64'h0,            1,   0,    0,  BUB,            2'd0, 1);  // drained
        add(1, 64'h11,           0,   0,    0,  BUB,            2'd0, 1);
        add(1, 64'h22,           0,   0,    1,  64'h11,         2'd1, 1);
        add(1, 64'hDEAD,         0,   1,    1,  64'h11,         2'd2, 0);  // flush in TWO
        add(0, 64'h0,            1,   0,    0,  BUB,            2'd0, 1);
        add(1, 64'hDEAD,         1,   1,    0,  BUB,            2'd0, 1);  // flush eats in_fire
        add(0, 64'h0,            1,   0,    0,  BUB,            2'd0, 1);
        add(1, 64'h1,            1,   0,    0,  BUB,            2'd0, 1);  // stream 1..4
        add(1, 64'h2,            1,   0,    1,  64'h1,          2'd1, 1);
        add(1, 64'h3,            1,   0,    1,  64'h2,          2'd1, 1);
        add(1, 64'h4,            1,   0,    1,  64'h3,          2'd1, 1);
        add(0, 64'h0,            1,   0,    1,  64'h4,          2'd1, 1);
        add(0, 64'h0,            1,   0,    0,  BUB,            2'd0, 1);
        add(1, 64'h55,           1,   0,    0,  BUB,            2'd0, 1);
        add(1, 64'h66,           1,   1,    1,  64'h55,         2'd1, 1);  // flush + out_fire
        add(0, 64'h0,            1,   0,    0,  BUB,            2'd0, 1);

        #7;
        check_reset("rst_hold");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_reset("rst_release");

        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk);
            #1;
            drive(tbl[i].iv, tbl[i].d, tbl[i].orr, tbl[i].fl);
            @(negedge clk);
            check($sformatf("v%0d_out_valid", i), word_t'(bus1.out_valid), word_t'(tbl[i].ov));
            check($sformatf("v%0d_out_data", i),  bus1.out_data,           tbl[i].od);
            check($sformatf("v%0d_occupancy", i), word_t'(bus1.occupancy), word_t'(tbl[i].occ));
            check($sformatf("v%0d_in_ready", i),  word_t'(bus1.in_ready),  word_t'(tbl[i].ir));
            if (!tbl[i].orr && bus0.out_valid)
                check($sformatf("v%0d_s0_stall_ready", i), word_t'(bus0.in_ready), 64'd0);
        end

        // Mid-cycle asynchronous reset while the skid stage holds two entries.
        @(posedge clk);
        #1;
        drive(1'b1, 64'hA1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        drive(1'b1, 64'hA2, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        check("pre_rst_s1_occupancy", word_t'(bus1.occupancy), 64'd2);
        check("pre_rst_s0_occupancy", word_t'(bus0.occupancy), 64'd1);
        rst_n = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0);
        #1;
        check_reset("rst_async");
        @(posedge clk);
        #1;
        check_reset("rst_async_held");
        rst_n = 1'b1;
        check_reset("rst_async_release");

        // Random traffic, the scoreboard checks every cycle.
        repeat (400) begin
            @(posedge clk);
            #1;
            drive(1'($urandom_range(0, 1)), {$urandom, $urandom},
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) == 0));
        end

        // Bounded drain.
        @(posedge clk);
        #1;
        drive(1'b0, '0, 1'b1, 1'b0);
        for (int k = 0; k < 10 && !(bus1.occupancy == 2'd0 && bus0.occupancy == 2'd0); k++) begin
            @(posedge clk);
            #1;
        end
        check("drain_s1_occupancy", word_t'(bus1.occupancy), 64'd0);
        check("drain_s0_occupancy", word_t'(bus0.occupancy), 64'd0);
        @(negedge clk);
        check("drain_s1_queue", word_t'(sb1.size()), 64'd0);
        check("drain_s0_queue", word_t'(sb0.size()), 64'd0);
        check("drain_s1_bubble", bus1.out_data, BUB);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
